pacman_mover: RTL
=================

// Module: pacman_mover
// PURPOSE
//   Player movement stage directly upstream of ghost_controller: turns level-sensitive direction
//   keys into Pac-Man grid coordinates pacman_x/pacman_y, which feed ghost_controller unchanged.
//   Once per MOVE_PERIOD clocks it tries the buffered turn, else continues straight. Walls come from
//   the maze wall memory over a 1-cycle read port. Horizontal tunnel wrap at grid edges.
// PARAMETERS
//   GRID_W       20  columns, x legal 0..GRID_W-1 (<=32)
//   GRID_H       20  rows, y legal 0..GRID_H-1 (<=32)
//   START_X      1   reset x
//   START_Y      1   reset y
//   MOVE_PERIOD  8   clocks between move attempts; must be >=6 (elaboration $error otherwise)
// PORTS
//   clk          in   1  system clock
//   reset        in   1  synchronous, active-high
//   key_up       in   1  level, request up
//   key_right    in   1  level, request right
//   key_down     in   1  level, request down
//   key_left     in   1  level, request left
//   wall_rd_en   out  1  wall memory read strobe
//   wall_rd_x    out  5  read x address (already wrapped)
//   wall_rd_y    out  5  read y address
//   wall_is_wall in   1  1 = wall; valid the cycle after wall_rd_en
//   pacman_x     out  5  current x (to ghost_controller)
//   pacman_y     out  5  current y (to ghost_controller)
//   pacman_dir   out  2  current heading: 0 up, 1 right, 2 down, 3 left
//   moved        out  1  1-cycle pulse, high in first cycle new position is visible
// BEHAVIOUR
//   Reset: pacman_x=START_X, pacman_y=START_Y, pacman_dir=3, queued_valid=0, tick counter=0,
//     FSM=IDLE, wall_rd_en=0, wall_rd_x/y=0, moved=0. Reset mid-attempt abandons the read.
//   Key buffer: any key high -> queued_dir <= highest-priority key (up>right>down>left),
//     queued_valid<=1. Sticky until consumed or overwritten; no keys = hold.
//   Tick: counter 0..MOVE_PERIOD-1, wraps; tick=1 when counter==MOVE_PERIOD-1. Free-running.
//   FSM: IDLE, REQ_Q, WAIT_Q, REQ_C, WAIT_C.
//     IDLE:   tick & queued_valid -> REQ_Q; tick & !queued_valid -> REQ_C; else stay.
//     REQ_Q:  wall_rd_en=1, address = neighbour of (x,y) in queued_dir -> WAIT_Q.
//     WAIT_Q: !wall_is_wall -> position<=neighbour, pacman_dir<=queued_dir, queued_valid<=0, -> IDLE;
//             wall -> REQ_C (queue kept).
//     REQ_C:  wall_rd_en=1, address = neighbour in pacman_dir -> WAIT_C.
//     WAIT_C: !wall -> position<=neighbour, -> IDLE; wall -> no move, -> IDLE.
//   Latency: tick in cycle T -> REQ at T+1, WAIT at T+2; queued success visible T+3,
//     straight move visible T+3 (no queue) or T+5 (queue blocked). moved=1 in that cycle only.
//   Neighbour/wrap: up y-1, down y+1, left x-1, right x+1. x=0 left -> GRID_W-1;
//     x=GRID_W-1 right -> 0. Vertical: y=0 up or y=GRID_H-1 down treated as wall, no read issued
//     (REQ state skips to next state as if wall; wall_rd_en stays 0).
//   Simultaneous: key high in the WAIT_Q cycle that consumes the queue -> new key wins
//     (queued_valid stays 1, queued_dir = new key). Queued_dir == pacman_dir handled normally.
//   Tick while FSM != IDLE is dropped (cannot occur with MOVE_PERIOD>=6).
//   wall_rd_x/y hold last address when wall_rd_en=0.
// TESTING
//   1 Reset, no keys, empty maze -> first move T+3 after tick: x 1->0, dir 3, moved one pulse.
//   2 At x=0 heading left, open row -> next move x=GRID_W-1 (19), y unchanged; wall_rd_x=19.
//   3 key_up 1 clk at (5,5) dir 1, wall at (5,4) -> REQ_Q reads (5,4), REQ_C reads (6,5),
//     x=6 at T+5; queue kept; next tick with (5..,4) open turns up, dir=0.
//   4 key_up & key_left together -> queued_dir=0 (priority); at y=0 up blocked -> no rd_en, no move.
//   5 Walls all four sides, keys idle -> wall_rd_en pulses each tick, position constant, moved=0.
//   6 reset asserted in WAIT_Q -> next cycle all outputs at reset values, no move committed.

Source files
------------

// File: rtl/pacman_mover.sv
// pacman_mover -- player movement stage feeding ghost_controller.
// Turns level-sensitive direction keys into grid coordinates. Once every
// MOVE_PERIOD clocks it tries the buffered turn; if that is blocked (or
// nothing is buffered) it continues straight in the current heading.
// Walls are looked up through a 1-cycle-latency wall memory read port.
// Horizontal edges wrap (tunnel); vertical edges act as walls.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   key_up/right/down/left      level-sensitive direction requests
//   wall_rd_en                  wall memory read strobe
//   wall_rd_x, wall_rd_y        read address (x already wrapped); held when idle
//   wall_is_wall                1 = wall, valid the cycle after wall_rd_en
//   pacman_x, pacman_y          current grid position
//   pacman_dir                  current heading: 0 up, 1 right, 2 down, 3 left
//   moved                       1-cycle pulse in the first cycle a new position shows
module pacman_mover #(
  parameter int GRID_W      = 20,
  parameter int GRID_H      = 20,
  parameter int START_X     = 1,
  parameter int START_Y     = 1,
  parameter int MOVE_PERIOD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_up,
  input  logic       key_right,
  input  logic       key_down,
  input  logic       key_left,
  output logic       wall_rd_en,
  output logic [4:0] wall_rd_x,
  output logic [4:0] wall_rd_y,
  input  logic       wall_is_wall,
  output logic [4:0] pacman_x,
  output logic [4:0] pacman_y,
  output logic [1:0] pacman_dir,
  output logic       moved
);

  if (MOVE_PERIOD < 6) begin : g_period_check
    $error("pacman_mover: MOVE_PERIOD must be >= 6");
  end

  localparam int CW = $clog2(MOVE_PERIOD);

  typedef enum logic [2:0] {IDLE, REQ_Q, WAIT_Q, REQ_C, WAIT_C} state_t;

  typedef struct packed {
    logic       blocked;
    logic [4:0] x;
    logic [4:0] y;
  } nb_t;

  // Neighbouring cell in a direction; vertical grid edges report blocked.
  function automatic nb_t neighbour(input logic [1:0] dir, input logic [4:0] x,
                                    input logic [4:0] y);
    nb_t n;
    n.blocked = 1'b0;
    n.x       = x;
    n.y       = y;
    case (dir)
      2'd0: if (y == 5'd0) n.blocked = 1'b1; else n.y = y - 5'd1;
      2'd1: n.x = (x == 5'(GRID_W - 1)) ? '0 : x + 5'd1;
      2'd2: if (y == 5'(GRID_H - 1)) n.blocked = 1'b1; else n.y = y + 5'd1;
      default: n.x = (x == 5'd0) ? 5'(GRID_W - 1) : x - 5'd1;
    endcase
    return n;
  endfunction

  state_t        state, state_n;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          queued_valid;
  logic [1:0]    queued_dir;
  logic [1:0]    req_dir;
  logic [4:0]    addr_x_q, addr_y_q;
  logic          any_key;
  logic [1:0]    key_dir;
  logic          commit, take_q;
  nb_t           nb_q, nb_c;

  assign tick = (tick_cnt == CW'(MOVE_PERIOD - 1));
  assign nb_q = neighbour(queued_dir, pacman_x, pacman_y);
  assign nb_c = neighbour(pacman_dir, pacman_x, pacman_y);

  always_comb begin
    any_key = key_up | key_right | key_down | key_left;
    key_dir = 2'd3;
    if (key_up)         key_dir = 2'd0;
    else if (key_right) key_dir = 2'd1;
    else if (key_down)  key_dir = 2'd2;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic; a blocked vertical edge skips the read as if it hit a wall.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (tick) state_n = queued_valid ? REQ_Q : REQ_C;
      REQ_Q:   state_n = nb_q.blocked ? REQ_C : WAIT_Q;
      WAIT_Q:  state_n = wall_is_wall ? REQ_C : IDLE;
      REQ_C:   state_n = nb_c.blocked ? IDLE : WAIT_C;
      WAIT_C:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs: read strobe/address and move commit controls.
  always_comb begin
    wall_rd_en = 1'b0;
    wall_rd_x  = addr_x_q;
    wall_rd_y  = addr_y_q;
    commit     = 1'b0;
    take_q     = 1'b0;
    case (state)
      REQ_Q: if (!nb_q.blocked) begin
        wall_rd_en = 1'b1;
        wall_rd_x  = nb_q.x;
        wall_rd_y  = nb_q.y;
      end
      REQ_C: if (!nb_c.blocked) begin
        wall_rd_en = 1'b1;
        wall_rd_x  = nb_c.x;
        wall_rd_y  = nb_c.y;
      end
      WAIT_Q: if (!wall_is_wall) begin
        commit = 1'b1;
        take_q = 1'b1;
      end
      WAIT_C: if (!wall_is_wall) commit = 1'b1;
      default: ;
    endcase
  end

  // Datapath. The committed target is the latched read address rather than a
  // recomputed neighbour, so a key arriving mid-attempt cannot skew the move.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt     <= '0;
      queued_valid <= 1'b0;
      queued_dir   <= '0;
      req_dir      <= '0;
      addr_x_q     <= '0;
      addr_y_q     <= '0;
      pacman_x     <= 5'(START_X);
      pacman_y     <= 5'(START_Y);
      pacman_dir   <= 2'd3;
      moved        <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
      if (wall_rd_en) begin
        addr_x_q <= wall_rd_x;
        addr_y_q <= wall_rd_y;
      end
      if (state == REQ_Q) req_dir <= queued_dir;
      if (commit) begin
        pacman_x <= addr_x_q;
        pacman_y <= addr_y_q;
      end
      if (take_q) pacman_dir <= req_dir;
      moved <= commit;
      // A key in the consuming cycle overrides the clear.
      if (any_key) begin
        queued_valid <= 1'b1;
        queued_dir   <= key_dir;
      end else if (take_q) begin
        queued_valid <= 1'b0;
      end
    end
  end

endmodule
